inverse_matrix_ctrl: RTL and testbench
======================================

Name: inverse_matrix_ctrl

Overview:
Sequencer for the 5x5 inverse_matrix datapath. On a start pulse it steps the datapath element address through 0..24 to load the source matrix, then waits a fixed settle time for the inverse to resolve. It checks the determinant for zero, then streams the 25 result words out row-major over a valid/ready interface. It sits between the system command logic and inverse_matrix, and owns the address bus.

Parameters:
N, 5, matrix dimension; element count is N*N.
DW, 32, data word width.
AW, 5, address width; must satisfy 2^AW > N*N.
LOAD_CYC, 2, clock cycles each address is held during load; legal range is 1 or more.
SETTLE_CYC, 4, cycles waited after the last address before the results are sampled; legal range is 1 or more.
TIMEOUT_CYC, 64, stall limit used only when INV_CTRL_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a run
address  out  AW  element address driven to inverse_matrix
load_en  out  1  high while address holds a valid load index
res_flat  in  N*N*DW  inverse results, row-major; element k occupies bits [k*DW +: DW]
det_in  in  DW  determinant from the datapath
out_data  out  DW  streamed result word
out_idx  out  AW  row-major index of out_data
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  downstream accepts the word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run finishes
singular  out  1  sticky; set when det_in==0 at CHECK, cleared by the next accepted start

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. When reset is sampled high: state=IDLE; address=0, load_en=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, singular=0; all counters cleared.
- Reset mid-run: aborts the run on that edge with no done pulse and no partial flags.
- IDLE:
  - start=1 moves the FSM to LOAD, with address=0, load_en=1, singular cleared.
  - start is ignored in every state other than IDLE.
- LOAD:
  - Each address is held LOAD_CYC cycles, then increments.
  - After index N*N-1 has been held LOAD_CYC cycles: load_en=0, address returns to 0, FSM goes to SETTLE.
  - Total LOAD duration is exactly N*N*LOAD_CYC cycles.
- SETTLE: counts SETTLE_CYC cycles, then goes to CHECK.
- CHECK: one cycle. It samples det_in, and res_flat into an internal N*N*DW capture register, on the same edge.
  - det_in==0: singular=1, then DONE. No words are streamed.
  - Otherwise the FSM goes to STREAM with idx=0.
- STREAM:
  - out_valid=1; out_data=capture[idx]; out_idx=idx.
  - The word transfers on a cycle where out_valid and out_ready are both high; idx then increments.
  - While out_ready is low, out_data and out_idx hold stable and out_valid stays high. out_valid never drops before a transfer.
  - The transfer of idx N*N-1 drops out_valid and moves the FSM to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle that follows.
- Result stability: captured results are immune to res_flat changes after CHECK.
- Latency: from start to the first out_valid is 1 + N*N*LOAD_CYC + SETTLE_CYC + 1 cycles. With defaults this is 56.
- Back-to-back runs: start asserted in the cycle after done is accepted. start asserted in the same cycle as done is ignored.

Optional Feature:
INV_CTRL_TIMEOUT_EN
- Defined:
  - A stall counter in STREAM increments on each cycle with out_valid=1 and out_ready=0, and clears on any transfer.
  - When the counter reaches TIMEOUT_CYC, the FSM aborts to DONE: out_valid drops, and the extra 1-bit output port timeout is set.
  - timeout is sticky; it is cleared by the next accepted start or by reset.
- Undefined: no counter and no timeout port; STREAM waits indefinitely.

Test Plan:
- Nominal run: defaults, out_ready tied 1, det_in=32'h0000_0010, res_flat element k = k+100. Required: address steps 0..24, each held 2 cycles; first out_valid 56 cycles after start; 25 consecutive words 100..124 with out_idx 0..24; done pulses once.
- Singular matrix: det_in=0. Required: singular=1, zero out_valid cycles, done pulses 1 cycle after CHECK, busy low the following cycle.
- Backpressure: out_ready low for 5 cycles at idx=7. Required: out_data=107 and out_idx=7 held stable; out_valid held high; no skipped or duplicated index.
- Start during busy, reset mid-LOAD: start pulsed at address=10 is ignored. reset at address=12 returns all outputs to reset values next cycle with no done; a fresh start restarts from address 0.
- Timeout (INV_CTRL_TIMEOUT_EN defined, TIMEOUT_CYC=8): out_ready held 0 from idx=3. Required: timeout=1 and out_valid=0 after 8 stall cycles; done pulses; the next start clears timeout.

Source files
------------

// File: rtl/inverse_matrix_ctrl.sv
// Load/settle/check/stream sequencer for the 5x5 inverse_matrix datapath.
// Optional stream stall timeout is enabled with `define INV_CTRL_TIMEOUT_EN.
module inverse_matrix_ctrl #(
    parameter int N           = 5,
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int LOAD_CYC    = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [AW-1:0]     address,
    output logic              load_en,
    input  logic [N*N*DW-1:0] res_flat,
    input  logic [DW-1:0]     det_in,
    output logic [DW-1:0]     out_data,
    output logic [AW-1:0]     out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              singular
`ifdef INV_CTRL_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int unsigned LAST    = N * N - 1;
    localparam int unsigned MAX_LS  = (LOAD_CYC > SETTLE_CYC) ? LOAD_CYC : SETTLE_CYC;
    localparam int unsigned CNT_MAX = (MAX_LS > TIMEOUT_CYC) ? MAX_LS : TIMEOUT_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        STREAM,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic                      load_en_q, load_en_d;
    logic [DW-1:0]             out_data_q, out_data_d;
    logic [AW-1:0]             out_idx_q, out_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      singular_q, singular_d;
    logic [N*N-1:0][DW-1:0]    cap_q, cap_d;
`ifdef INV_CTRL_TIMEOUT_EN
    logic                      timeout_q, timeout_d;
`endif

    // One counter serves load hold, settle wait and stream stall, since those phases never overlap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        load_en_d   = load_en_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        singular_d  = singular_q;
        cap_d       = cap_q;
`ifdef INV_CTRL_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    load_en_d  = 1'b1;
                    singular_d = 1'b0;
                    cnt_d      = '0;
`ifdef INV_CTRL_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (cnt_q == CW'(LOAD_CYC - 1)) begin
                    cnt_d = '0;
                    if (addr_q == AW'(LAST)) begin
                        addr_d    = '0;
                        load_en_d = 1'b0;
                        state_d   = SETTLE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                cap_d = res_flat;
                if (det_in == '0) begin
                    singular_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d     = STREAM;
                    out_valid_d = 1'b1;
                    out_idx_d   = '0;
                    out_data_d  = res_flat[DW-1:0];
                end
            end
            STREAM: begin
                if (out_ready) begin
                    cnt_d = '0;
                    if (out_idx_q == AW'(LAST)) begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        out_idx_d  = out_idx_q + AW'(1);
                        out_data_d = cap_q[out_idx_q + AW'(1)];
                    end
                end
`ifdef INV_CTRL_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    out_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            load_en_q   <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            singular_q  <= 1'b0;
            cap_q       <= '0;
`ifdef INV_CTRL_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            load_en_q   <= load_en_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            singular_q  <= singular_d;
            cap_q       <= cap_d;
`ifdef INV_CTRL_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign address   = addr_q;
    assign load_en   = load_en_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign singular  = singular_q;
`ifdef INV_CTRL_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_inverse_matrix_ctrl.sv
// Randomized bench for inverse_matrix_ctrl against a cycle-timeline reference model.
// Covers timeout behaviour when INV_CTRL_TIMEOUT_EN is defined.
module tb_inverse_matrix_ctrl;

    localparam int N        = 5;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int NN       = N * N;
    localparam int LOAD_CYC = 2;
    localparam int SET_CYC  = 4;
`ifdef INV_CTRL_TIMEOUT_EN
    localparam int TO       = 8;
`else
    localparam int TO       = 64;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     address;
    logic              load_en;
    logic [NN*DW-1:0]  res_flat;
    logic [DW-1:0]     det_in;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              singular;
`ifdef INV_CTRL_TIMEOUT_EN
    logic              timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] w [NN];
    bit exp_sing = 1'b0;
    bit exp_to   = 1'b0;

    inverse_matrix_ctrl #(
        .N(N), .DW(DW), .AW(AW), .LOAD_CYC(LOAD_CYC), .SETTLE_CYC(SET_CYC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .address(address), .load_en(load_en),
        .res_flat(res_flat), .det_in(det_in), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .singular(singular)
`ifdef INV_CTRL_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int k = 0; k < NN; k++) res_flat[k*DW +: DW] = $urandom;
        det_in = $urandom;
    endtask

    // mode: 0 random ready (pct), 1 five-cycle stall at idx 7, 2 stall forever from idx 3, 3 always ready
    task automatic run_once(input bit fixed_data, input bit sing, input int mode, input int pct,
                            input bit poke, input bit start_at_done);
        int pos, stall, bp, guard;
        bit aborted;
        for (int k = 0; k < NN; k++) begin
            w[k] = fixed_data ? DW'(k + 100) : DW'($urandom);
            res_flat[k*DW +: DW] = w[k];
        end
        det_in = sing ? '0 : (fixed_data ? 32'h0000_0010 : ($urandom | 32'h1));
        step();
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
        check("idle_load_en", load_en, 0);
        check("idle_singular", singular, exp_sing);
`ifdef INV_CTRL_TIMEOUT_EN
        check("idle_timeout", timeout, exp_to);
`endif
        exp_sing = sing;
        exp_to = 1'b0;
        for (int c = 1; c <= NN * LOAD_CYC; c++) begin
            step();
            start = (poke && c == 21);
            @(negedge clk);
            check("load_addr", address, (c - 1) / LOAD_CYC);
            check("load_en", load_en, 1);
            check("load_busy", busy, 1);
            check("load_valid", out_valid, 0);
            check("load_done", done, 0);
            check("load_singular", singular, 0);
`ifdef INV_CTRL_TIMEOUT_EN
            check("load_timeout", timeout, 0);
`endif
        end
        for (int c = 0; c <= SET_CYC; c++) begin
            step();
            start = 1'b0;
            @(negedge clk);
            check("settle_addr", address, 0);
            check("settle_load_en", load_en, 0);
            check("settle_busy", busy, 1);
            check("settle_valid", out_valid, 0);
            check("settle_done", done, 0);
        end
        aborted = 1'b0;
        if (!sing) begin
            pos = 0; stall = 0; bp = 0; guard = 0;
            while (pos < NN && !aborted && guard < 3000) begin
                step();
                if (guard == 0) scramble();
                case (mode)
                    0: out_ready = ($urandom_range(99) < pct);
                    1: if (pos == 7 && bp < 5) begin out_ready = 1'b0; bp++; end
                       else out_ready = 1'b1;
                    2: out_ready = (pos < 3);
                    default: out_ready = 1'b1;
                endcase
                @(negedge clk);
                check("stream_valid", out_valid, 1);
                check("stream_data", out_data, w[pos]);
                check("stream_idx", out_idx, pos);
                check("stream_busy", busy, 1);
                check("stream_done", done, 0);
                if (out_ready) begin
                    pos++;
                    stall = 0;
                end else begin
                    stall++;
                end
`ifdef INV_CTRL_TIMEOUT_EN
                if (stall == TO) aborted = 1'b1;
`endif
                guard++;
            end
            if (guard >= 3000) check("stream_bound", pos, NN);
        end
        step();
        start = start_at_done;
        out_ready = 1'b0;
        if (sing) scramble();
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 1);
        check("done_singular", singular, sing);
`ifdef INV_CTRL_TIMEOUT_EN
        check("done_timeout", timeout, aborted);
`endif
        exp_to = aborted;
    endtask

    task automatic reset_mid_load();
        step();
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 25; c++) begin
            step();
            start = 1'b0;
            if (c == 25) reset = 1'b1;
            @(negedge clk);
            check("rst_load_addr", address, (c - 1) / LOAD_CYC);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_addr", address, 0);
        check("rst_load_en", load_en, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_singular", singular, 0);
`ifdef INV_CTRL_TIMEOUT_EN
        check("rst_timeout", timeout, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("rst_after_done", done, 0);
            check("rst_after_busy", busy, 0);
        end
        exp_sing = 1'b0;
        exp_to = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        res_flat = '0;
        det_in = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("init_addr", address, 0);
        check("init_load_en", load_en, 0);
        check("init_data", out_data, 0);
        check("init_idx", out_idx, 0);
        check("init_valid", out_valid, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_singular", singular, 0);
        step();
        reset = 1'b0;
        @(negedge clk);

        run_once(1'b1, 1'b0, 3, 100, 1'b0, 1'b0);   // nominal
        run_once(1'b0, 1'b1, 3, 100, 1'b0, 1'b1);   // singular, start during done
        run_once(1'b0, 1'b0, 1, 100, 1'b0, 1'b0);   // backpressure at idx 7
        run_once(1'b0, 1'b0, 0, 70, 1'b1, 1'b0);    // start during busy
        reset_mid_load();
        for (int r = 0; r < 6; r++) begin
            run_once(1'b0, ($urandom_range(3) == 0), 0, 40 + $urandom_range(60), 1'b0,
                     bit'($urandom_range(1)));
        end
`ifdef INV_CTRL_TIMEOUT_EN
        run_once(1'b0, 1'b0, 2, 100, 1'b0, 1'b0);   // stall forever from idx 3
        run_once(1'b1, 1'b0, 3, 100, 1'b0, 1'b0);
`endif
        step();
        start = 1'b0;
        @(negedge clk);
        check("final_busy", busy, 0);
        check("final_done", done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
